// File: rtl/fp_mult_link_pkg.sv
// fp_mult_link_pkg: shared definitions for the fp_mult host adapter.
//   state_e        - controller state encoding
//   OPERAND_BYTES  - bytes streamed into fp_mult per operation ({Y,X})
//   RESULT_BYTES   - bytes collected from fp_mult per operation
//   FP64_QNAN      - product returned when the watchdog expires
package fp_mult_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_WAIT = 3'd2,
    ST_RECV = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int OPERAND_BYTES = 16;
  localparam int RESULT_BYTES  = 8;

  localparam logic [63:0] FP64_QNAN = 64'h7FF8_0000_0000_0000;

endpackage

// File: rtl/fp_mult_link.sv
// fp_mult_link: host-side adapter in front of the byte-serial fp_mult core.
// Accepts a pair of IEEE-754 doubles, streams them LSB-first (X then Y) into
// fp_mult, waits for READY under a watchdog, gathers the 8 product bytes and
// hands the 64-bit result back over a valid/ready handshake.
//
// Ports:
//   clk_i, rst_n_i          clock, async active-low reset
//   in_valid_i/in_ready_o   operand handshake, x_i/y_i sampled on accept
//   out_valid_o/out_ready_i result handshake, result_o/timeout_err_o held
//   mult_reset_o            active-high reset to fp_mult (high while idle)
//   mult_enable_o           fp_mult ENABLE, high while streaming operands
//   mult_data_in_o          fp_mult DATA_IN
//   mult_data_out_i         fp_mult DATA_OUT
//   mult_ready_i            fp_mult READY
//
// state | meaning
// IDLE  | multiplier held in reset, waiting for operands
// SEND  | one operand byte per cycle on mult_data_in_o (16 cycles)
// WAIT  | watchdog running, waiting for mult_ready_i
// RECV  | capturing product bytes 1..7
// DONE  | result presented until the host takes it
module fp_mult_link
  import fp_mult_link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [63:0] x_i,
  input  logic [63:0] y_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] result_o,
  output logic        timeout_err_o,
  output logic        mult_reset_o,
  output logic        mult_enable_o,
  output logic [7:0]  mult_data_in_o,
  input  logic [7:0]  mult_data_out_i,
  input  logic        mult_ready_i
);

  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES);
  localparam logic [3:0] LAST_OP_BYTE  = 4'(OPERAND_BYTES - 1);
  localparam logic [3:0] LAST_RES_BYTE = 4'(RESULT_BYTES - 1);

  state_e              state_q;
  logic [127:0]        shift_q;
  logic [3:0]          byte_cnt_q;
  logic [3:0]          byte_cnt_d;
  logic [WDOG_W-1:0]   wdog_q;
  logic [WDOG_W-1:0]   wdog_d;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [63:0]         result_q;
  logic                timeout_err_q;
  logic                mult_reset_q;
  logic                mult_enable_q;
  logic [7:0]          mult_data_in_q;

  assign byte_cnt_d = byte_cnt_q + 4'd1;
  assign wdog_d     = wdog_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q        <= ST_IDLE;
      shift_q        <= '0;
      byte_cnt_q     <= '0;
      wdog_q         <= '0;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      result_q       <= '0;
      timeout_err_q  <= 1'b0;
      mult_reset_q   <= 1'b1;
      mult_enable_q  <= 1'b0;
      mult_data_in_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid_i && in_ready_q) begin
            // Byte 0 goes straight to the output register; the shift
            // register keeps the remaining 15 bytes.
            mult_data_in_q <= x_i[7:0];
            shift_q        <= {8'h00, y_i, x_i[63:8]};
            byte_cnt_q     <= '0;
            wdog_q         <= '0;
            timeout_err_q  <= 1'b0;
            in_ready_q     <= 1'b0;
            mult_reset_q   <= 1'b0;
            mult_enable_q  <= 1'b1;
            state_q        <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (byte_cnt_q == LAST_OP_BYTE) begin
            mult_enable_q  <= 1'b0;
            mult_data_in_q <= '0;
            state_q        <= ST_WAIT;
          end else begin
            mult_data_in_q <= shift_q[7:0];
            shift_q        <= {8'h00, shift_q[127:8]};
            byte_cnt_q     <= byte_cnt_d;
          end
        end
        ST_WAIT: begin
          wdog_q <= wdog_d;
          // READY takes priority over a watchdog expiry on the same edge.
          if (mult_ready_i) begin
            result_q[7:0] <= mult_data_out_i;
            byte_cnt_q    <= 4'd1;
            state_q       <= ST_RECV;
          end else if (wdog_d == WDOG_LIMIT) begin
            result_q      <= FP64_QNAN;
            timeout_err_q <= 1'b1;
            out_valid_q   <= 1'b1;
            state_q       <= ST_DONE;
          end
        end
        ST_RECV: begin
          result_q[{byte_cnt_q[2:0], 3'b000} +: 8] <= mult_data_out_i;
          if (byte_cnt_q == LAST_RES_BYTE) begin
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            byte_cnt_q <= byte_cnt_d;
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            mult_reset_q <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o     = in_ready_q;
  assign out_valid_o    = out_valid_q;
  assign result_o       = result_q;
  assign timeout_err_o  = timeout_err_q;
  assign mult_reset_o   = mult_reset_q;
  assign mult_enable_o  = mult_enable_q;
  assign mult_data_in_o = mult_data_in_q;

endmodule

// File: tb/tb_fp_mult_link.sv
// tb_fp_mult_link: bench for fp_mult_link with a behavioural fp_mult model
// (configurable READY delay or no READY at all) and a result scoreboard.
module tb_fp_mult_link;

  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] x;
  logic [63:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        timeout_err;
  logic        mult_reset;
  logic        mult_enable;
  logic [7:0]  mult_data_in;
  logic [7:0]  m_dout;
  logic        m_ready;

  fp_mult_link #(.TIMEOUT_CYCLES(64)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .x_i            (x),
    .y_i            (y),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .result_o       (result),
    .timeout_err_o  (timeout_err),
    .mult_reset_o   (mult_reset),
    .mult_enable_o  (mult_enable),
    .mult_data_in_o (mult_data_in),
    .mult_data_out_i(m_dout),
    .mult_ready_i   (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) * $bitstoreal(b));
  endfunction

  // ---------------- behavioural fp_mult ----------------
  int           m_delay = 0;
  bit           m_hang  = 1'b0;
  logic [127:0] m_op;
  logic [63:0]  m_prod;
  int           m_cnt, m_dcnt, m_oidx, m_phase;

  always @(posedge clk) begin
    if (mult_reset) begin
      m_cnt   <= 0;
      m_phase <= 0;
      m_ready <= 1'b0;
      m_dout  <= 8'h00;
    end else begin
      case (m_phase)
        0: if (mult_enable) begin
          m_op  <= {mult_data_in, m_op[127:8]};
          m_cnt <= m_cnt + 1;
          if (m_cnt == 15) begin
            m_prod <= fmul(m_op[71:8], {mult_data_in, m_op[127:72]});
            if (m_hang) m_phase <= 3;
            else if (m_delay == 0) begin
              m_ready <= 1'b1;
              m_dout  <= fmul(m_op[71:8], {mult_data_in, m_op[127:72]}) & 64'hFF;
              m_oidx  <= 1;
              m_phase <= 2;
            end else begin
              m_dcnt  <= m_delay;
              m_phase <= 1;
            end
          end
        end
        1: begin
          m_dcnt <= m_dcnt - 1;
          if (m_dcnt == 1) begin
            m_ready <= 1'b1;
            m_dout  <= m_prod[7:0];
            m_oidx  <= 1;
            m_phase <= 2;
          end
        end
        2: begin
          m_ready <= 1'b0;
          m_dout  <= m_prod[8*m_oidx +: 8];
          m_oidx  <= m_oidx + 1;
          if (m_oidx == 7) m_phase <= 3;
        end
        default: ;
      endcase
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [64:0] sb[$];
  bit          b2b_chk = 1'b0;
  int          b2b_start = 0;

  initial begin
    int          last_ov_edge;
    int          acc_edge;
    logic        ov_prev;
    logic [64:0] e;
    logic [64:0] g;
    last_ov_edge = -1;
    ov_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        ov_prev = 1'b0;
      end else begin
        if (out_valid && !ov_prev) last_ov_edge = cyc;
        ov_prev = out_valid;
        if (in_valid && in_ready) begin
          acc_edge = cyc + 1;
          if (m_hang) sb.push_back({1'b1, QNAN});
          else        sb.push_back({1'b0, fmul(x, y)});
          if (b2b_chk && last_ov_edge > b2b_start)
            check_eq("b2b_gap", 65'(acc_edge - last_ov_edge), 65'd2);
        end
        if (out_valid && out_ready) begin
          g = {timeout_err, result};
          if (sb.size() == 0) begin
            check_eq("sb_unexpected_output", 65'(sb.size()), 65'd1);
          end else begin
            e = sb.pop_front();
            if (e[62:52] == 11'h7FF && e[51:0] != 52'd0) begin
              e[51] = 1'b0;
              g[51] = 1'b0;
            end
            check_eq("result", g, e);
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_time_limit: got cycle %0d expected completion", cyc);
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns with the accept edge just behind us; a0 = its edge index.
  task automatic send_op(input logic [63:0] xa, input logic [63:0] ya, output int a0);
    int n;
    x = xa;
    y = ya;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) check_eq("accept_wait", 65'(in_ready), 65'd1);
    tick();
    in_valid = 1'b0;
    a0 = cyc;
  endtask

  task automatic wait_ov(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 300) begin
      tick();
      n++;
    end
    if (!out_valid) check_eq(tag, 65'(out_valid), 65'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int          a0;
    int          n;
    logic [127:0] op;
    logic [63:0] snap;

    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = '0;
    y = '0;
    #1 rst_n = 1'b0;
    #3;
    check_eq("rst_flags", 65'({in_ready, mult_reset, out_valid, mult_enable, timeout_err}), 65'b11000);
    check_eq("rst_data_in", 65'(mult_data_in), 65'd0);
    check_eq("rst_result", 65'(result), 65'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1.0 x 2.0, READY after 3 wait cycles
    m_delay = 3;
    m_hang  = 1'b0;
    op = {64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000};
    send_op(op[63:0], op[127:64], a0);
    for (int k = 0; k < 16; k++) begin
      check_eq($sformatf("send_byte%0d", k), 65'({mult_enable, mult_data_in}), 65'({1'b1, op[8*k +: 8]}));
      tick();
    end
    check_eq("wait_enable_data", 65'({mult_enable, mult_data_in}), 65'd0);
    wait_ov("ov_wait_1x2");
    check_eq("ov_edge_1x2", 65'(cyc - a0), 65'd27);
    check_eq("result_1x2", 65'({timeout_err, result}), {1'b0, 64'h4000_0000_0000_0000});
    consume();

    // Watchdog: multiplier never raises READY
    m_hang = 1'b1;
    send_op(64'h4008_0000_0000_0000, 64'h4010_0000_0000_0000, a0);
    wait_ov("ov_wait_timeout");
    check_eq("ov_edge_timeout", 65'(cyc - a0), 65'd80);
    check_eq("timeout_result", 65'({timeout_err, result}), {1'b1, QNAN});

    // Backpressure in DONE with stray IN_VALID pulses
    snap = result;
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      x = {$urandom, $urandom};
      tick();
    end
    in_valid = 1'b0;
    check_eq("bp_hold", 65'({out_valid, in_ready}), 65'b10);
    check_eq("bp_result_stable", 65'(result), 65'(snap));
    consume();

    // Next transaction clears TIMEOUT_ERR on accept
    m_hang = 1'b0;
    m_delay = 0;
    send_op(64'h4008_0000_0000_0000, 64'hBFE0_0000_0000_0000, a0);
    check_eq("err_cleared", 65'(timeout_err), 65'd0);
    wait_ov("ov_wait_after_timeout");
    consume();

    // Reset during SEND byte 5
    m_delay = 1;
    send_op(64'h4014_0000_0000_0000, 64'h4018_0000_0000_0000, a0);
    for (int k = 0; k < 5; k++) tick();
    check_eq("send_byte5_pre_reset", 65'(mult_data_in), 65'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_flags", 65'({in_ready, mult_reset, out_valid, mult_enable, timeout_err}), 65'b11000);
    check_eq("arst_data_in", 65'(mult_data_in), 65'd0);
    check_eq("arst_result", 65'(result), 65'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send_op(64'h3FF8_0000_0000_0000, 64'h3FF8_0000_0000_0000, a0);
    wait_ov("ov_wait_1p5");
    check_eq("result_1p5", 65'(result), 65'(64'h4002_0000_0000_0000));
    consume();

    // Back-to-back with random operands
    b2b_start = cyc;
    b2b_chk = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      m_delay = $urandom_range(0, 3);
      n = 0;
      while (!in_ready && n < 200) begin
        tick();
        n++;
      end
      if (!in_ready) check_eq("b2b_accept_wait", 65'(in_ready), 65'd1);
      tick();
    end
    in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check_eq("sb_drain", 65'(sb.size()), 65'd0);
    b2b_chk = 1'b0;
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
